// File: rtl/mod_99_vr_mpacket_tx_pkg.sv
// Shared constants for the 802.3br verify/respond mPacket transmit path:
// state encodings, SMD values, mCRC mask and CRC-32 parameters.
package mod_99_vr_mpacket_tx_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PREAMBLE = 3'd1;
    localparam logic [2:0] ST_SMD      = 3'd2;
    localparam logic [2:0] ST_DATA     = 3'd3;
    localparam logic [2:0] ST_MCRC     = 3'd4;
    localparam logic [2:0] ST_IPG      = 3'd5;

    localparam int MP_PREAMBLE_OCTETS = 7;
    localparam int MP_DATA_OCTETS     = 60;
    localparam int MP_IPG_OCTETS      = 12;

    localparam logic [7:0]  MP_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  MP_SMD_V         = 8'h07;
    localparam logic [7:0]  MP_SMD_R         = 8'h19;
    localparam logic [31:0] MP_MCRC_XOR      = 32'h0000_FFFF;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

    function automatic logic [31:0] bit_rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Octets go on the wire LSB first, so the engine runs the reflected polynomial.
    localparam logic [31:0] CRC32_POLY_REFL = bit_rev32(CRC32_POLY);

endpackage

// File: rtl/mod_99_vr_mpacket_tx_crc32_octet.sv
// Octet-wide Ethernet CRC-32; o_fcs is the complemented running value, ready
// to send least-significant octet first. Shared with the receive-side checker.
module mod_99_vr_mpacket_tx_crc32_octet
    import mod_99_vr_mpacket_tx_pkg::*;
(
    input  logic        clk,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_fcs
);

    logic [31:0] r_crc;
    logic [31:0] w_next;

    always_comb begin
        w_next = r_crc ^ {24'h0, i_data};
        for (int i = 0; i < 8; i++) begin
            w_next = w_next[0] ? ((w_next >> 1) ^ CRC32_POLY_REFL) : (w_next >> 1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_init) begin
            r_crc <= CRC32_INIT;
        end else if (i_en) begin
            r_crc <= w_next;
        end
    end

    assign o_fcs = ~r_crc;

endmodule

// File: rtl/mod_99_vr_mpacket_tx.sv
// Serialises one verify or respond mPacket (preamble, SMD, zero payload, mCRC)
// per request onto a valid/ready octet stream, then enforces the inter-packet gap.
module mod_99_vr_mpacket_tx
    import mod_99_vr_mpacket_tx_pkg::*;
#(
    parameter int          PREAMBLE_OCTETS = MP_PREAMBLE_OCTETS,
    parameter logic [7:0]  SMD_V           = MP_SMD_V,
    parameter logic [7:0]  SMD_R           = MP_SMD_R,
    parameter int          DATA_OCTETS     = MP_DATA_OCTETS,
    parameter logic [31:0] MCRC_XOR        = MP_MCRC_XOR,
    parameter int          IPG_OCTETS      = MP_IPG_OCTETS
) (
    input  logic       clk,
    input  logic       reset_begin,
    input  logic       link_fail,
    input  logic       send_v,
    input  logic       send_r,
    input  logic       mac_tx_busy,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       send_v_clr,
    output logic       send_r_clr,
    output logic [2:0] tx_state
);

    // Handshake: an octet moves on a cycle with tx_valid && tx_ready; while
    // tx_valid && !tx_ready the octet, sop and eop hold and no counter advances.

    logic [2:0]  r_state;
    logic        r_kind_r;
    logic        r_tx_valid;
    logic        r_tx_sop;
    logic [7:0]  r_tx_data;
    logic [3:0]  r_pre_cnt;
    logic [5:0]  r_data_cnt;
    logic [1:0]  r_crc_cnt;
    logic [3:0]  r_ipg_cnt;

    logic        w_abort;
    logic        w_xfer;
    logic        w_last_xfer;
    logic        w_crc_en;
    logic        w_crc_init;
    logic [31:0] w_fcs;
    logic [31:0] w_mcrc;

    assign w_abort     = reset_begin || link_fail;
    assign w_xfer      = r_tx_valid && tx_ready;
    assign w_last_xfer = (r_state == ST_MCRC) && (r_crc_cnt == 2'd3) && w_xfer && !w_abort;
    assign w_crc_en    = (r_state == ST_DATA) && w_xfer;
    assign w_crc_init  = w_abort || (r_state == ST_IDLE);
    assign w_mcrc      = w_fcs ^ MCRC_XOR;

    mod_99_vr_mpacket_tx_crc32_octet u_crc (
        .clk    (clk),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_data (r_tx_data),
        .o_fcs  (w_fcs)
    );

    always_ff @(posedge clk) begin
        if (w_abort) begin
            r_state    <= ST_IDLE;
            r_kind_r   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_data  <= 8'h00;
            r_pre_cnt  <= 4'd0;
            r_data_cnt <= 6'd0;
            r_crc_cnt  <= 2'd0;
            r_ipg_cnt  <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((send_r || send_v) && !mac_tx_busy) begin
                        r_kind_r   <= send_r;
                        r_state    <= ST_PREAMBLE;
                        r_tx_valid <= 1'b1;
                        r_tx_sop   <= 1'b1;
                        r_tx_data  <= MP_PREAMBLE_BYTE;
                        r_pre_cnt  <= 4'd0;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_xfer) begin
                        r_tx_sop <= 1'b0;
                        if (r_pre_cnt == 4'(PREAMBLE_OCTETS - 1)) begin
                            r_state   <= ST_SMD;
                            r_tx_data <= r_kind_r ? SMD_R : SMD_V;
                        end else begin
                            r_pre_cnt <= r_pre_cnt + 4'd1;
                        end
                    end
                end
                ST_SMD: begin
                    if (w_xfer) begin
                        r_state    <= ST_DATA;
                        r_tx_data  <= 8'h00;
                        r_data_cnt <= 6'd0;
                    end
                end
                ST_DATA: begin
                    if (w_xfer) begin
                        if (r_data_cnt == 6'(DATA_OCTETS - 1)) begin
                            r_state   <= ST_MCRC;
                            r_crc_cnt <= 2'd0;
                        end else begin
                            r_data_cnt <= r_data_cnt + 6'd1;
                        end
                    end
                end
                ST_MCRC: begin
                    if (w_xfer) begin
                        if (r_crc_cnt == 2'd3) begin
                            r_state    <= ST_IPG;
                            r_tx_valid <= 1'b0;
                            r_tx_data  <= 8'h00;
                            r_ipg_cnt  <= 4'd0;
                        end else begin
                            r_crc_cnt <= r_crc_cnt + 2'd1;
                        end
                    end
                end
                ST_IPG: begin
                    if (r_ipg_cnt == 4'(IPG_OCTETS - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_ipg_cnt <= r_ipg_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // mCRC octets come straight from the settled FCS register, which is only
    // updated during DATA, so they are stable across stalls.
    always_comb begin
        tx_data = r_tx_data;
        if (r_state == ST_MCRC) begin
            case (r_crc_cnt)
                2'd0:    tx_data = w_mcrc[7:0];
                2'd1:    tx_data = w_mcrc[15:8];
                2'd2:    tx_data = w_mcrc[23:16];
                default: tx_data = w_mcrc[31:24];
            endcase
        end
    end

    assign tx_valid   = r_tx_valid;
    assign tx_sop     = r_tx_sop;
    assign tx_eop     = (r_state == ST_MCRC) && (r_crc_cnt == 2'd3);
    assign send_v_clr = w_last_xfer && !r_kind_r;
    assign send_r_clr = w_last_xfer && r_kind_r;
    assign tx_state   = r_state;

endmodule

// File: tb/tb_mod_99_vr_mpacket_tx.sv
// Bench for the mPacket transmitter: directed scenarios with randomized ready,
// checked against a bit-serial Ethernet FCS reference and a byte-level packet model.
module tb_mod_99_vr_mpacket_tx;

    logic       clk;
    logic       reset_begin;
    logic       link_fail;
    logic       send_v;
    logic       send_r;
    logic       mac_tx_busy;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_sop;
    logic       tx_eop;
    logic       send_v_clr;
    logic       send_r_clr;
    logic [2:0] tx_state;

    mod_99_vr_mpacket_tx dut (
        .clk         (clk),
        .reset_begin (reset_begin),
        .link_fail   (link_fail),
        .send_v      (send_v),
        .send_r      (send_r),
        .mac_tx_busy (mac_tx_busy),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_sop      (tx_sop),
        .tx_eop      (tx_eop),
        .send_v_clr  (send_v_clr),
        .send_r_clr  (send_r_clr),
        .tx_state    (tx_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int sop_n, eop_n, vclr_n, rclr_n;
    int sop_cyc, eop_cyc, vclr_cyc, rclr_cyc, sop_idx, eop_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ethernet FCS, bit-serial MSB-first shift register fed LSB-first per octet.
    function automatic logic [31:0] model_fcs(input int n_zero);
        logic [31:0] sr;
        logic [31:0] fcs;
        logic [7:0]  oct;
        logic        fb;
        sr = 32'hFFFF_FFFF;
        for (int k = 0; k < n_zero; k++) begin
            oct = 8'h00;
            for (int i = 0; i < 8; i++) begin
                fb = sr[31] ^ oct[i];
                sr = {sr[30:0], 1'b0};
                if (fb) sr = sr ^ 32'h04C11DB7;
            end
        end
        sr = ~sr;
        for (int i = 0; i < 32; i++) fcs[i] = sr[31-i];
        return fcs;
    endfunction

    task automatic build_exp(input bit respond);
        logic [31:0] m;
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(respond ? 8'h19 : 8'h07);
        for (int i = 0; i < 60; i++) exp_q.push_back(8'h00);
        m = model_fcs(60) ^ 32'h0000_FFFF;
        for (int i = 0; i < 4; i++) exp_q.push_back(m[8*i +: 8]);
    endtask

    // ---------------- driver / collector ----------------
    // Runs from posedge+1; samples at negedge. abort_sel: 1 = reset, 2 = link_fail.
    task automatic collect(input int max_cyc, input bit rnd, input int stall_at,
                           input int abort_at, input int abort_sel, input bit drop_on_sop,
                           output bit completed);
        bit prev_stall, done;
        int phase, stall_left;
        logic [7:0] pd;
        logic ps, pe;
        got_q.delete();
        sop_n = 0; eop_n = 0; vclr_n = 0; rclr_n = 0;
        sop_cyc = -1; eop_cyc = -1; vclr_cyc = -1; rclr_cyc = -1; sop_idx = -1; eop_idx = -1;
        prev_stall = 0; done = 0; phase = 0; stall_left = 5; completed = 0;
        pd = 8'h00; ps = 1'b0; pe = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            tx_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (stall_at >= 0 && got_q.size() >= stall_at && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end
            if (phase == 1) begin
                reset_begin = 1'b0; link_fail = 1'b0; send_v = 1'b0; send_r = 1'b0;
                phase = 2;
            end else if (phase == 0 && abort_at >= 0 && got_q.size() == abort_at) begin
                if (abort_sel == 1) reset_begin = 1'b1;
                else link_fail = 1'b1;
                phase = 1;
            end
            @(negedge clk);
            if (send_v_clr) begin vclr_n++; vclr_cyc = cyc; send_v = 1'b0; end
            if (send_r_clr) begin rclr_n++; rclr_cyc = cyc; send_r = 1'b0; end
            if (phase == 2) begin
                check("abort_valid", {31'h0, tx_valid}, 32'h0);
                check("abort_state", {29'h0, tx_state}, 32'h0);
                check("abort_eop", {31'h0, tx_eop}, 32'h0);
                done = 1;
            end else begin
                if (prev_stall)
                    check("stall_hold", {21'h0, tx_valid, tx_sop, tx_eop, tx_data},
                          {21'h0, 1'b1, ps, pe, pd});
                if (tx_valid && tx_ready) begin
                    if (tx_sop) begin
                        sop_n++;
                        if (sop_cyc < 0) begin sop_cyc = cyc; sop_idx = got_q.size(); end
                    end
                    if (tx_eop) begin
                        eop_n++; eop_cyc = cyc; eop_idx = got_q.size();
                        done = 1; completed = 1;
                    end
                    got_q.push_back(tx_data);
                    if (drop_on_sop && tx_sop) begin send_v = 1'b0; send_r = 1'b0; end
                end
                prev_stall = tx_valid && !tx_ready;
                ps = tx_sop; pe = tx_eop; pd = tx_data;
            end
            @(posedge clk); #1;
        end
        if (!done) check("collect_timeout", 32'(c_timeout_flag(done)), 32'h0);
    endtask

    function automatic int c_timeout_flag(input bit done_flag);
        return done_flag ? 0 : 1;
    endfunction

    task automatic check_packet(input bit respond, input bit completed);
        int bad;
        logic [31:0] mc;
        build_exp(respond);
        check("pkt_done", {31'h0, completed}, 32'h1);
        check("pkt_len", got_q.size(), 72);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check("pkt_bytes", bad, 0);
        mc = (got_q.size() >= 72) ? {got_q[71], got_q[70], got_q[69], got_q[68]} : 32'h0;
        check("pkt_mcrc", mc, model_fcs(60) ^ 32'h0000_FFFF);
        check("pkt_sop_n", sop_n, 1);
        check("pkt_sop_idx", sop_idx, 0);
        check("pkt_eop_idx", eop_idx, 71);
        if (respond) begin
            check("pkt_rclr_n", rclr_n, 1);
            check("pkt_rclr_cyc", rclr_cyc, eop_cyc);
            check("pkt_vclr_n", vclr_n, 0);
        end else begin
            check("pkt_vclr_n", vclr_n, 1);
            check("pkt_vclr_cyc", vclr_cyc, eop_cyc);
            check("pkt_rclr_n", rclr_n, 0);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int lc, prev_eop, vcnt;
        reset_begin = 1'b1; link_fail = 1'b0; send_v = 1'b0; send_r = 1'b0;
        mac_tx_busy = 1'b0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_begin = 1'b0;
        @(negedge clk);
        check("rst_state", {29'h0, tx_state}, 32'h0);
        check("rst_outs", {26'h0, tx_valid, tx_sop, tx_eop, send_v_clr, send_r_clr, 1'b0}, 32'h0);
        check("rst_data", {24'h0, tx_data}, 32'h0);
        @(posedge clk); #1;

        // Verify mPacket, request dropped once the packet has started.
        send_v = 1'b1;
        lc = cyc;
        collect(300, 1'b0, -1, -1, 0, 1'b1, ok);
        check_packet(1'b0, ok);
        check("v_latency", sop_cyc, lc + 1);

        // Both requests raised during the gap: respond goes first, verify after.
        prev_eop = eop_cyc;
        send_v = 1'b1; send_r = 1'b1;
        collect(300, 1'b0, -1, -1, 0, 1'b0, ok);
        check_packet(1'b1, ok);
        check("gap_v_to_r", sop_cyc - prev_eop, 14);
        prev_eop = eop_cyc;
        collect(300, 1'b0, -1, -1, 0, 1'b0, ok);
        check_packet(1'b0, ok);
        check("gap_r_to_v", sop_cyc - prev_eop, 14);

        // Busy transmit path holds off the launch.
        idle_cycles(15);
        mac_tx_busy = 1'b1; send_v = 1'b1; vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_valid) vcnt++;
            @(posedge clk); #1;
        end
        check("busy_no_valid", vcnt, 0);
        mac_tx_busy = 1'b0;
        lc = cyc;
        collect(300, 1'b0, -1, -1, 0, 1'b0, ok);
        check_packet(1'b0, ok);
        check("busy_latency", sop_cyc, lc + 1);

        // Random back-pressure with a 5-cycle stall inside the payload.
        idle_cycles(15);
        send_v = 1'b1;
        collect(2000, 1'b1, 20, -1, 0, 1'b0, ok);
        check_packet(1'b0, ok);

        // Reset at octet 30, then a fresh request resends the whole packet.
        idle_cycles(15);
        send_v = 1'b1;
        collect(300, 1'b0, -1, 30, 1, 1'b0, ok);
        check("rst_abort_eop", eop_n, 0);
        check("rst_abort_vclr", vclr_n, 0);
        send_v = 1'b1;
        collect(300, 1'b0, -1, -1, 0, 1'b0, ok);
        check_packet(1'b0, ok);

        // link_fail during the mCRC octets of a respond mPacket.
        idle_cycles(15);
        send_r = 1'b1;
        collect(300, 1'b0, -1, 69, 2, 1'b0, ok);
        check("lf_abort_eop", eop_n, 0);
        check("lf_abort_rclr", rclr_n, 0);
        check("lf_abort_len", got_q.size(), 70);
        idle_cycles(3);
        @(negedge clk);
        check("lf_idle_state", {29'h0, tx_state}, 32'h0);
        check("lf_idle_valid", {31'h0, tx_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
